clkdiv_bank: RTL and testbench



---
 rtl/clkdiv_bank_pkg.sv | 29 ++
 rtl/clkdiv_chan.sv | 86 ++++++++
 rtl/clkdiv_bank.sv | 108 ++++++++++
 tb/tb_clkdiv_bank.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_bank_pkg.sv
// rtl/clkdiv_bank_pkg.sv - shared types, defaults and helpers for clkdiv_bank
// Contents:
//   CFG_MAX_W   widest divide/high/phase field the config struct can carry
//   DEF_*       default parameter values for the bank and its channels
//   ch_cfg_t    one channel's configuration (div, high, phase), zero-extended
//   reset_high  high-cycle count used at reset: half the default period
package clkdiv_bank_pkg;

  localparam int unsigned CFG_MAX_W = 32;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_DIV_W         = 8;
  localparam int DEF_DEFAULT_DIV   = 9;
  localparam int DEF_LOCK_CYCLES   = 16;
  localparam bit DEF_GATE_UNLOCKED = 1'b1;

  // Fields are carried at CFG_MAX_W so one struct serves any DIV_W;
  // each channel keeps only its low DIV_W bits.
  typedef struct packed {
    logic [CFG_MAX_W-1:0] div;
    logic [CFG_MAX_W-1:0] high;
    logic [CFG_MAX_W-1:0] phase;
  } ch_cfg_t;

  function automatic logic [CFG_MAX_W-1:0] reset_high(input int unsigned default_div);
    return (default_div + 32'd1) / 32'd2;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one programmable divide/duty/phase waveform channel
// Ports:
//   clk      in   fabric clock
//   rst      in   synchronous active-high reset, restores default config
//   load     in   take cfg as the new div/high/phase and restart cnt from phase
//   restart  in   restart cnt from the stored phase (bank-wide realignment)
//   gate     in   force ch_out/ch_tick low for this cycle (bank unlocked)
//   cfg      in   configuration presented with load
//   ch_out   out  registered waveform, high while cnt < high
//   ch_tick  out  registered one-cycle pulse when cnt == div
module clkdiv_chan
  import clkdiv_bank_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    restart,
  input  logic    gate,
  input  ch_cfg_t cfg,
  output logic    ch_out,
  output logic    ch_tick
);

  localparam logic [CFG_MAX_W-1:0] RST_DIV_FULL  = CFG_MAX_W'(DEFAULT_DIV);
  localparam logic [CFG_MAX_W-1:0] RST_HIGH_FULL = reset_high(DEFAULT_DIV);
  localparam logic [DIV_W-1:0]     RST_DIV       = RST_DIV_FULL[DIV_W-1:0];
  localparam logic [DIV_W-1:0]     RST_HIGH      = RST_HIGH_FULL[DIV_W-1:0];

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] high_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt_q;

  logic [DIV_W-1:0] new_div;
  logic [DIV_W-1:0] new_high;
  logic [DIV_W-1:0] new_phase;

  assign new_div   = cfg.div[DIV_W-1:0];
  assign new_high  = cfg.high[DIV_W-1:0];
  assign new_phase = cfg.phase[DIV_W-1:0];

  // Upper struct bits are zero padding from the top level.
  if (DIV_W < CFG_MAX_W) begin : g_pad
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{cfg.div[CFG_MAX_W-1:DIV_W],
                               cfg.high[CFG_MAX_W-1:DIV_W],
                               cfg.phase[CFG_MAX_W-1:DIV_W]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= RST_DIV;
      high_q  <= RST_HIGH;
      phase_q <= '0;
      cnt_q   <= '0;
      ch_out  <= 1'b0;
      ch_tick <= 1'b0;
    end else begin
      if (load) begin
        div_q   <= new_div;
        high_q  <= new_high;
        phase_q <= new_phase;
      end

      // A phase beyond the period cannot be reached by the counter, so it
      // is clamped to a clean start at 0.
      if (load) begin
        cnt_q <= (new_phase <= new_div) ? new_phase : '0;
      end else if (restart) begin
        cnt_q <= (phase_q <= div_q) ? phase_q : '0;
      end else if (cnt_q == div_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end

      // Outputs follow the pre-edge counter, giving one clock of latency.
      ch_out  <= !gate && (cnt_q < high_q);
      ch_tick <= !gate && (cnt_q == div_q);
    end
  end

endmodule

// File: rtl/clkdiv_bank.sv
// rtl/clkdiv_bank.sv - N-channel runtime-configurable clock-enable/waveform bank
// Ports:
//   clk_in1    in   sole fabric clock
//   rst        in   synchronous active-high reset, discards runtime config
//   cfg_we     in   single-cycle config write strobe
//   cfg_ch     in   target channel; values >= NUM_CH are rejected
//   cfg_div    in   period minus one
//   cfg_high   in   high cycles per period
//   cfg_phase  in   counter start value
//   ch_out     out  per-channel registered waveform
//   ch_tick    out  per-channel registered end-of-period pulse
//   locked     out  config stable for LOCK_CYCLES clocks
//   cfg_err    out  one-cycle pulse after a write to a nonexistent channel
// Build option: CLKDIV_BANK_ALIGN_EN makes every valid write restart all
// channels from their own phase; otherwise only the written channel restarts.
module clkdiv_bank
  import clkdiv_bank_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int DIV_W         = DEF_DIV_W,
  parameter int DEFAULT_DIV   = DEF_DEFAULT_DIV,
  parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES,
  parameter bit GATE_UNLOCKED = DEF_GATE_UNLOCKED
) (
  input  logic                    clk_in1,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NUM_CH):0] cfg_ch,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [DIV_W-1:0]        cfg_high,
  input  logic [DIV_W-1:0]        cfg_phase,
  output logic [NUM_CH-1:0]       ch_out,
  output logic [NUM_CH-1:0]       ch_tick,
  output logic                    locked,
  output logic                    cfg_err
);

  localparam int CH_W = $clog2(NUM_CH) + 1;
  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [CH_W-1:0] NUM_CH_V = CH_W'(NUM_CH);
  localparam logic [LK_W-1:0] LOCK_TOP = LK_W'(LOCK_CYCLES);

  logic            ch_ok;
  logic            wr_ok;
  logic [LK_W-1:0] lock_cnt_q;
  logic [LK_W-1:0] lock_cnt_d;
  logic            locked_d;
  logic            gate;
  logic            restart_all;
  ch_cfg_t         wr_cfg;

  assign ch_ok = (cfg_ch < NUM_CH_V);
  assign wr_ok = cfg_we && ch_ok;

  assign wr_cfg.div   = CFG_MAX_W'(cfg_div);
  assign wr_cfg.high  = CFG_MAX_W'(cfg_high);
  assign wr_cfg.phase = CFG_MAX_W'(cfg_phase);

`ifdef CLKDIV_BANK_ALIGN_EN
  assign restart_all = wr_ok;
`else
  assign restart_all = 1'b0;
`endif

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (wr_ok) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_TOP) begin
      lock_cnt_d = lock_cnt_q + LK_W'(1);
    end
  end

  // Gate on the post-edge lock state so the outputs are never seen high
  // in a cycle where locked reads 0.
  assign locked_d = (lock_cnt_d == LOCK_TOP);
  assign gate     = GATE_UNLOCKED && !locked_d;

  always_ff @(posedge clk_in1) begin
    if (rst) begin
      lock_cnt_q <= '0;
      cfg_err    <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      cfg_err    <= cfg_we && !ch_ok;
    end
  end

  assign locked = (lock_cnt_q == LOCK_TOP);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk_in1),
      .rst     (rst),
      .load    (wr_ok && (cfg_ch == CH_W'(i))),
      .restart (restart_all),
      .gate    (gate),
      .cfg     (wr_cfg),
      .ch_out  (ch_out[i]),
      .ch_tick (ch_tick[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb/tb_clkdiv_bank.sv - self-checking bench for clkdiv_bank
module tb_clkdiv_bank;

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] tick;
    logic       locked;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_high = '0;
  logic [7:0] cfg_phase = '0;
  logic [3:0] ch_out;
  logic [3:0] ch_tick;
  logic       locked;
  logic       cfg_err;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb[$];
  exp_t mon_e;

  int m_div[4];
  int m_high[4];
  int m_phase[4];
  int m_cnt[4];
  int m_lock;

  clkdiv_bank #(
    .NUM_CH        (4),
    .DIV_W         (8),
    .DEFAULT_DIV   (9),
    .LOCK_CYCLES   (16),
    .GATE_UNLOCKED (1'b1)
  ) dut (
    .clk_in1   (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .ch_out    (ch_out),
    .ch_tick   (ch_tick),
    .locked    (locked),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every driven cycle pushes its expected post-edge outputs.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if ({ch_out, ch_tick, locked, cfg_err} !== mon_e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t: out=%b tick=%b locked=%b err=%b, want out=%b tick=%b locked=%b err=%b",
                 $time, ch_out, ch_tick, locked, cfg_err,
                 mon_e.out, mon_e.tick, mon_e.locked, mon_e.err);
      end
    end
  end

  task automatic model_step(input bit r, input bit we, input int ch,
                            input int d, input int h, input int p);
    exp_t e;
    bit   valid;
    bit   align;
    int   lock_n;
    e = '0;
    align = 1'b0;
`ifdef CLKDIV_BANK_ALIGN_EN
    align = 1'b1;
`endif
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_div[i] = 9; m_high[i] = 5; m_phase[i] = 0; m_cnt[i] = 0;
      end
      m_lock = 0;
    end else begin
      valid  = we && (ch < 4);
      lock_n = valid ? 0 : ((m_lock < 16) ? m_lock + 1 : 16);
      for (int i = 0; i < 4; i++) begin
        if (lock_n == 16) begin
          e.out[i]  = (m_cnt[i] < m_high[i]);
          e.tick[i] = (m_cnt[i] == m_div[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (valid && ch == i) begin
          m_div[i] = d; m_high[i] = h; m_phase[i] = p;
          m_cnt[i] = (p <= d) ? p : 0;
        end else if (align && valid) begin
          m_cnt[i] = (m_phase[i] <= m_div[i]) ? m_phase[i] : 0;
        end else begin
          m_cnt[i] = (m_cnt[i] == m_div[i]) ? 0 : m_cnt[i] + 1;
        end
      end
      m_lock   = lock_n;
      e.locked = (lock_n == 16);
      e.err    = we && (ch >= 4);
    end
    sb.push_back(e);
  endtask

  // One clock: drive on the falling edge, predict, return 2 time units
  // after the rising edge so callers sample settled outputs.
  task automatic cycle(input bit r, input bit we, input int ch,
                       input int d, input int h, input int p);
    @(negedge clk);
    rst = r; cfg_we = we; cfg_ch = 3'(ch);
    cfg_div = 8'(d); cfg_high = 8'(h); cfg_phase = 8'(p);
    model_step(r, we, ch, d, h, p);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1, 3, 1, 0);
    vectors++;
    if ({ch_out, ch_tick} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 00", {ch_out, ch_tick});
    end
    vectors++;
    if ({locked, cfg_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00", {locked, cfg_err});
    end
    for (int n = 1; n <= 16; n++) begin
      idle(1);
      if (n == 15) begin
        vectors++;
        if (locked !== 1'b0) begin
          miscompares++;
          $display("FAIL lock_early: locked=%b at 15 want 0", locked);
        end
      end
      if (n == 16) begin
        vectors++;
        if (locked !== 1'b1) begin
          miscompares++;
          $display("FAIL lock_at_16: locked=%b want 1", locked);
        end
      end
    end
  endtask

  task automatic test_default_period;
    int ones[4];
    int ticks[4];
    int first_tick;
    int second_tick;
    int out_of_phase;
    first_tick = -1; second_tick = -1; out_of_phase = 0;
    for (int i = 0; i < 4; i++) begin ones[i] = 0; ticks[i] = 0; end
    for (int n = 0; n < 20; n++) begin
      idle(1);
      for (int i = 0; i < 4; i++) begin
        ones[i]  += int'(ch_out[i]);
        ticks[i] += int'(ch_tick[i]);
      end
      if (ch_out !== 4'h0 && ch_out !== 4'hf) out_of_phase++;
      if (ch_tick[0] === 1'b1) begin
        if (first_tick < 0) first_tick = n;
        else if (second_tick < 0) second_tick = n;
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ones[i] != 10 || ticks[i] != 2) begin
        miscompares++;
        $display("FAIL default_duty ch%0d: ones=%0d ticks=%0d want 10/2", i, ones[i], ticks[i]);
      end
    end
    vectors++;
    if (second_tick - first_tick != 10) begin
      miscompares++;
      $display("FAIL default_tick_spacing: got %0d want 10", second_tick - first_tick);
    end
    vectors++;
    if (out_of_phase != 0) begin
      miscompares++;
      $display("FAIL default_in_phase: %0d cycles disagree want 0", out_of_phase);
    end
  endtask

  task automatic test_write_ch1;
    int ones1, ticks1, ones0, ticks0;
    ones1 = 0; ticks1 = 0; ones0 = 0; ticks0 = 0;
    cycle(1'b0, 1'b1, 1, 3, 1, 0);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL write_unlocks: locked=%b want 0", locked);
    end
    idle(16);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL write_relock: locked=%b want 1", locked);
    end
    for (int n = 0; n < 20; n++) begin
      idle(1);
      ones1 += int'(ch_out[1]); ticks1 += int'(ch_tick[1]);
      ones0 += int'(ch_out[0]); ticks0 += int'(ch_tick[0]);
    end
    vectors++;
    if (ones1 != 5 || ticks1 != 5) begin
      miscompares++;
      $display("FAIL ch1_div4: ones=%0d ticks=%0d want 5/5", ones1, ticks1);
    end
    vectors++;
    if (ones0 != 10 || ticks0 != 2) begin
      miscompares++;
      $display("FAIL ch0_kept: ones=%0d ticks=%0d want 10/2", ones0, ticks0);
    end
  endtask

  task automatic test_phase_lead;
    logic a1[10];
    logic a2[10];
    logic t0[10];
    int   bad;
    int   ones2;
    bad = 0; ones2 = 0;
    cycle(1'b0, 1'b1, 1, 3, 2, 0);
    idle(3);
    cycle(1'b0, 1'b1, 2, 3, 2, 2);
    idle(16);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL phase_relock: locked=%b want 1", locked);
    end
    for (int j = 0; j < 10; j++) begin
      idle(1);
      a1[j] = ch_out[1]; a2[j] = ch_out[2]; t0[j] = ch_tick[0];
      if (j < 8) ones2 += int'(ch_out[2]);
    end
    for (int j = 0; j < 8; j++) if (a2[j] !== a1[j+2]) bad++;
    vectors++;
    if (bad != 0 || ones2 != 4) begin
      miscompares++;
      $display("FAIL phase_lead2: bad=%0d ones2=%0d want 0/4", bad, ones2);
    end
`ifdef CLKDIV_BANK_ALIGN_EN
    vectors++;
    if (t0[2] !== 1'b0 || t0[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL align_ch0_tick: t19=%b t20=%b want 0/1", t0[2], t0[3]);
    end
`else
    if (t0[0] === 1'bx) $display("note: ch0 tick unknown");
`endif
  endtask

  task automatic test_extremes_back_to_back;
    int lock_bad, c0, c1, c2, c3;
    logic t3_20;
    lock_bad = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0; t3_20 = 1'b0;
    cycle(1'b0, 1'b1, 0, 5, 0, 0);
    if (locked !== 1'b0) lock_bad++;
    cycle(1'b0, 1'b1, 1, 9, 12, 0);
    if (locked !== 1'b0) lock_bad++;
    cycle(1'b0, 1'b1, 2, 0, 1, 0);
    if (locked !== 1'b0) lock_bad++;
    cycle(1'b0, 1'b1, 3, 9, 5, 20);
    if (locked !== 1'b0) lock_bad++;
    vectors++;
    if (lock_bad != 0) begin
      miscompares++;
      $display("FAIL back_to_back_unlocked: %0d writes saw locked=1 want 0", lock_bad);
    end
    idle(15);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_lock_early: locked=%b want 0", locked);
    end
    idle(1);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_relock: locked=%b want 1", locked);
    end
    for (int j = 0; j < 14; j++) begin
      idle(1);
      c0 += int'(ch_out[0]);
      c1 += int'(ch_out[1]);
      c2 += int'(ch_tick[2]);
      c3 += int'(ch_tick[3]);
      if (j == 3) t3_20 = ch_tick[3];
    end
    vectors++;
    if (c0 != 0) begin
      miscompares++;
      $display("FAIL high0_const0: ones=%0d want 0", c0);
    end
    vectors++;
    if (c1 != 14) begin
      miscompares++;
      $display("FAIL high_gt_div_const1: ones=%0d want 14", c1);
    end
    vectors++;
    if (c2 != 14) begin
      miscompares++;
      $display("FAIL div0_tick_every: ticks=%0d want 14", c2);
    end
    vectors++;
    if (c3 != 2 || t3_20 !== 1'b1) begin
      miscompares++;
      $display("FAIL phase_clamp: ticks=%0d t20=%b want 2/1", c3, t3_20);
    end
  endtask

  task automatic test_bad_channel;
    cycle(1'b0, 1'b1, 5, 1, 1, 1);
    vectors++;
    if ({cfg_err, locked} !== 2'b11) begin
      miscompares++;
      $display("FAIL bad_ch5_err: err,locked=%b want 11", {cfg_err, locked});
    end
    idle(1);
    vectors++;
    if ({cfg_err, locked} !== 2'b01) begin
      miscompares++;
      $display("FAIL bad_ch5_pulse: err,locked=%b want 01", {cfg_err, locked});
    end
    cycle(1'b0, 1'b1, 4, 2, 2, 2);
    vectors++;
    if ({cfg_err, locked} !== 2'b11) begin
      miscompares++;
      $display("FAIL bad_ch4_err: err,locked=%b want 11", {cfg_err, locked});
    end
    idle(2);
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_ch4_pulse: err=%b want 0", cfg_err);
    end
  endtask

  task automatic test_reset_mid;
    int ones[4];
    int ticks0;
    int bad;
    ticks0 = 0; bad = 0;
    for (int i = 0; i < 4; i++) ones[i] = 0;
    cycle(1'b1, 1'b1, 0, 3, 1, 0);
    vectors++;
    if ({ch_out, ch_tick, locked, cfg_err} !== 10'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %b want all 0", {ch_out, ch_tick, locked, cfg_err});
    end
    idle(15);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_lock_early: locked=%b want 0", locked);
    end
    idle(1);
    vectors++;
    if (locked !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_relock: locked=%b want 1", locked);
    end
    for (int n = 0; n < 20; n++) begin
      idle(1);
      for (int i = 0; i < 4; i++) ones[i] += int'(ch_out[i]);
      ticks0 += int'(ch_tick[0]);
    end
    for (int i = 0; i < 4; i++) if (ones[i] != 10) bad++;
    vectors++;
    if (bad != 0 || ticks0 != 2) begin
      miscompares++;
      $display("FAIL midreset_defaults: bad_ch=%0d ticks0=%0d want 0/2", bad, ticks0);
    end
  endtask

  initial begin
    test_reset;
    test_default_period;
    test_write_ch1;
    test_phase_lead;
    test_extremes_back_to_back;
    test_bad_channel;
    test_reset_mid;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
